// File: rtl/im_prefetch_if.sv
// Fetch-port and instruction-memory signals of the prefetch queue.
// master is the prefetch unit's view; slave is the CPU + memory environment.
interface im_prefetch_if #(
   parameter int AW = 14
);
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_rdata;
   logic          cpu_valid;
   logic          cpu_wait;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   modport master (
      input  cpu_req, cpu_addr, mem_rvalid, mem_rdata,
      output cpu_rdata, cpu_valid, cpu_wait, mem_req, mem_addr
   );

   modport slave (
      output cpu_req, cpu_addr, mem_rvalid, mem_rdata,
      input  cpu_rdata, cpu_valid, cpu_wait, mem_req, mem_addr
   );
endinterface

// File: rtl/im_prefetch.sv
// Instruction prefetch queue: streams consecutive words ahead of the CPU and
// answers sequential fetches with SRAM timing; redirects flush and refetch.
module im_prefetch #(
   parameter int DEPTH = 4,
   parameter int AW    = 14
) (
   input logic           clk,
   input logic           rst,
   im_prefetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] q_addr [DEPTH];
   logic [31:0]   q_data [DEPTH];

   logic [PW-1:0] head_reg;
   logic [PW-1:0] tail_reg;
   logic [PW:0]   count_reg;
   logic          pending_reg;
   logic          discard_reg;
   logic          mem_req_reg;
   logic          cpu_valid_reg;
   logic [AW-1:0] pend_addr_reg;
   logic [AW-1:0] pf_addr_reg;
   logic [AW-1:0] mem_addr_reg;
   logic [31:0]   cpu_rdata_reg;

   logic          hit;
   logic          miss;
   logic          rsp;
   logic          deliver;
   logic          push;
   logic          issue;
   logic [AW-1:0] issue_addr;

   assign hit  = bus.cpu_req && (count_reg != '0) && (q_addr[head_reg] == bus.cpu_addr);
   assign miss = bus.cpu_req && !hit && (!pending_reg || (bus.cpu_addr != pend_addr_reg));
   // mem_req_reg doubles as the in-flight flag; stray rvalids are ignored.
   assign rsp  = bus.mem_rvalid && mem_req_reg;

   // On a redirect cycle the response is judged against the new target; only
   // a word that is exactly the new address, with nothing queued, is handed over.
   assign deliver = rsp && !discard_reg &&
                    (miss ? ((mem_addr_reg == bus.cpu_addr) && (count_reg == '0))
                          : (pending_reg && (mem_addr_reg == pend_addr_reg)));
   assign push    = rsp && !discard_reg && !deliver && !miss;

   assign issue      = !mem_req_reg && (miss || (count_reg != FULL));
   assign issue_addr = miss ? bus.cpu_addr : pf_addr_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[tail_reg] <= mem_addr_reg;
         q_data[tail_reg] <= bus.mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         pending_reg   <= 1'b0;
         discard_reg   <= 1'b0;
         mem_req_reg   <= 1'b0;
         cpu_valid_reg <= 1'b0;
         pend_addr_reg <= '0;
         pf_addr_reg   <= '0;
         mem_addr_reg  <= '0;
         cpu_rdata_reg <= '0;
      end else begin
         cpu_valid_reg <= hit || deliver;
         if (hit) begin
            cpu_rdata_reg <= q_data[head_reg];
         end else if (deliver) begin
            cpu_rdata_reg <= bus.mem_rdata;
         end

         // A request, once issued, is held until its response arrives.
         if (issue) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= issue_addr;
         end else if (rsp) begin
            mem_req_reg <= 1'b0;
         end

         if (miss) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            pending_reg   <= !deliver;
            pend_addr_reg <= bus.cpu_addr;
            pf_addr_reg   <= deliver ? bus.cpu_addr + 1'b1 : bus.cpu_addr;
            discard_reg   <= mem_req_reg && !rsp &&
                             ((mem_addr_reg != bus.cpu_addr) || (count_reg != '0));
         end else begin
            if (hit) begin
               head_reg <= head_reg + 1'b1;
            end
            if (push) begin
               tail_reg <= tail_reg + 1'b1;
            end
            unique case ({push, hit})
               2'b10:   count_reg <= count_reg + 1'b1;
               2'b01:   count_reg <= count_reg - 1'b1;
               default: count_reg <= count_reg;
            endcase
            if (deliver) begin
               pending_reg <= 1'b0;
               pf_addr_reg <= pend_addr_reg + 1'b1;
            end else if (push) begin
               pf_addr_reg <= pf_addr_reg + 1'b1;
            end
            if (rsp && discard_reg) begin
               discard_reg <= 1'b0;
            end
         end
      end
   end

   assign bus.cpu_rdata = cpu_rdata_reg;
   assign bus.cpu_valid = cpu_valid_reg;
   assign bus.cpu_wait  = pending_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_addr  = mem_addr_reg;
endmodule

// File: tb/tb_im_prefetch.sv
// Bench for im_prefetch: CPU fetch driver with a data scoreboard, and a
// variable-latency memory model that logs every accepted request address.
module tb_im_prefetch;
   localparam int AW    = 14;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   im_prefetch_if #(.AW(AW)) bus ();

   im_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0]   exp_q [$];
   logic [AW-1:0] mem_log [$];
   int            lat          = 2;
   int            last_rsp_cyc = -1;
   int            valid_cyc    = -1;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {10'h000, a, 8'h13};
   endfunction

   // Memory model: one request at a time, answered lat cycles after acceptance.
   initial begin : memory_model
      logic          busy;
      int            cnt;
      logic [AW-1:0] req_addr;
      busy = 1'b0;
      cnt = 0;
      req_addr = '0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            bus.mem_rvalid = 1'b0;
         end else if (bus.mem_rvalid) begin
            bus.mem_rvalid = 1'b0;
            vectors++;
            if (bus.mem_req !== 1'b0) begin
               miscompares++;
               $display("FAIL mem_req_drop: mem_req=%b after rvalid, required 0", bus.mem_req);
            end
         end else if (busy) begin
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== req_addr) begin
               miscompares++;
               $display("FAIL mem_hold: mem_req=%b mem_addr=%h, required 1 / %h",
                        bus.mem_req, bus.mem_addr, req_addr);
            end
            cnt--;
            if (cnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = mem_word(req_addr);
               busy = 1'b0;
               last_rsp_cyc = cyc;
            end
         end else if (bus.mem_req === 1'b1) begin
            busy = 1'b1;
            cnt = lat;
            req_addr = bus.mem_addr;
            mem_log.push_back(req_addr);
         end
      end
   end

   // Called just after a negedge; leaves cpu_req asserted on return.
   task automatic fetch(input logic [AW-1:0] a, output int waited);
      logic [31:0] exp;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      exp_q.push_back(mem_word(a));
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (bus.cpu_valid !== 1'b1 && bus.cpu_wait === 1'b1 && waited < 100);
      exp = exp_q.pop_front();
      valid_cyc = cyc;
      vectors++;
      if (bus.cpu_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL fetch_valid_%h: valid=%b wait=%b after %0d cycles, required valid=1",
                  a, bus.cpu_valid, bus.cpu_wait, waited);
      end else begin
         vectors++;
         if (bus.cpu_rdata !== exp) begin
            miscompares++;
            $display("FAIL fetch_data_%h: rdata=%h, required %h", a, bus.cpu_rdata, exp);
         end
      end
      $display("fetch addr=%h rdata=%h cycles=%0d", a, bus.cpu_rdata, waited);
   endtask

   task automatic idle(input int n);
      bus.cpu_req = 1'b0;
      repeat (n) begin
         @(negedge clk);
         vectors++;
         if (bus.cpu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_valid: cpu_valid=%b with no request, required 0", bus.cpu_valid);
         end
      end
   endtask

   task automatic test_reset();
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors += 5;
      if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: %h, required 0", bus.cpu_rdata); end
      if (bus.cpu_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_valid: %b, required 0", bus.cpu_valid); end
      if (bus.cpu_wait !== 1'b0)   begin miscompares++; $display("FAIL rst_wait: %b, required 0", bus.cpu_wait); end
      if (bus.mem_req !== 1'b0)    begin miscompares++; $display("FAIL rst_mem_req: %b, required 0", bus.mem_req); end
      if (bus.mem_addr !== '0)     begin miscompares++; $display("FAIL rst_mem_addr: %h, required 0", bus.mem_addr); end
   endtask

   task automatic test_cold_start();
      logic [31:0] exp;
      lat = 2;
      rst = 1'b0;
      mem_log.delete();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 14'h000;
      exp_q.push_back(mem_word(14'h000));
      @(negedge clk);
      vectors += 4;
      if (bus.mem_req !== 1'b1)     begin miscompares++; $display("FAIL cold_mem_req: %b, required 1", bus.mem_req); end
      if (bus.mem_addr !== 14'h000) begin miscompares++; $display("FAIL cold_mem_addr: %h, required 000", bus.mem_addr); end
      if (bus.cpu_wait !== 1'b1)    begin miscompares++; $display("FAIL cold_wait_c1: %b, required 1", bus.cpu_wait); end
      if (bus.cpu_valid !== 1'b0)   begin miscompares++; $display("FAIL cold_valid_c1: %b, required 0", bus.cpu_valid); end
      repeat (2) @(negedge clk);
      vectors += 2;
      if (bus.cpu_valid !== 1'b0) begin miscompares++; $display("FAIL cold_valid_c3: %b, required 0", bus.cpu_valid); end
      if (bus.cpu_wait !== 1'b1)  begin miscompares++; $display("FAIL cold_wait_c3: %b, required 1", bus.cpu_wait); end
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors += 4;
      if (bus.cpu_valid !== 1'b1) begin miscompares++; $display("FAIL cold_valid_c4: %b, required 1", bus.cpu_valid); end
      if (bus.cpu_rdata !== exp)  begin miscompares++; $display("FAIL cold_rdata: %h, required %h", bus.cpu_rdata, exp); end
      if (bus.cpu_wait !== 1'b0)  begin miscompares++; $display("FAIL cold_wait_c4: %b, required 0", bus.cpu_wait); end
      if (last_rsp_cyc !== cyc - 1) begin
         miscompares++;
         $display("FAIL cold_latency: rvalid at cycle %0d, valid at %0d, required valid one cycle after rvalid", last_rsp_cyc, cyc);
      end
      $display("fetch addr=000 rdata=%h cycles=4", bus.cpu_rdata);
   endtask

   task automatic test_fill_stream();
      int w;
      idle(25);
      repeat (4) begin
         @(negedge clk);
         vectors++;
         if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL full_no_req: mem_req=%b, required 0", bus.mem_req); end
      end
      vectors++;
      if (mem_log.size() != 5 || mem_log[4] !== 14'h004) begin
         miscompares++;
         $display("FAIL fill_log: %0d requests accepted, required 5 ending at 004", mem_log.size());
      end
      lat = 5;
      mem_log.delete();
      for (int i = 1; i <= 4; i++) begin
         fetch(AW'(i), w);
         vectors++;
         if (w != 1) begin miscompares++; $display("FAIL stream_hit_%0d: %0d cycles, required 1", i, w); end
         if (i == 2) begin
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 14'h005) begin
               miscompares++;
               $display("FAIL resume_prefetch: mem_req=%b mem_addr=%h, required 1 / 005", bus.mem_req, bus.mem_addr);
            end
         end
      end
   endtask

   task automatic test_redirect_discard();
      int w;
      fetch(14'h100, w);
      vectors++;
      if (mem_log.size() < 2 || mem_log[0] !== 14'h005 || mem_log[1] !== 14'h100) begin
         miscompares++;
         $display("FAIL discard_order: %0d requests logged, required 005 then 100", mem_log.size());
      end
   endtask

   task automatic test_redirect_inflight();
      int w;
      int n20;
      lat = 3;
      fetch(14'h01F, w);
      mem_log.delete();
      idle(1);
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 14'h020) begin
         miscompares++;
         $display("FAIL inflight_setup: mem_req=%b mem_addr=%h, required 1 / 020", bus.mem_req, bus.mem_addr);
      end
      fetch(14'h020, w);
      vectors++;
      if (valid_cyc != last_rsp_cyc + 1) begin
         miscompares++;
         $display("FAIL inflight_latency: valid at %0d, rvalid at %0d, required one cycle apart", valid_cyc, last_rsp_cyc);
      end
      idle(6);
      n20 = 0;
      foreach (mem_log[i]) if (mem_log[i] === 14'h020) n20++;
      vectors += 2;
      if (n20 != 1) begin miscompares++; $display("FAIL inflight_single_req: %0d requests to 020, required 1", n20); end
      if (mem_log.size() < 2 || mem_log[1] !== 14'h021) begin
         miscompares++;
         $display("FAIL inflight_next: %0d requests logged, required 021 second", mem_log.size());
      end
   endtask

   task automatic test_wrap();
      int w;
      lat = 1;
      fetch(14'h3FFE, w);
      mem_log.delete();
      idle(14);
      vectors++;
      if (mem_log.size() < 2 || mem_log[0] !== 14'h3FFF || mem_log[1] !== 14'h0000) begin
         miscompares++;
         $display("FAIL wrap_prefetch: %0d requests logged, required 3fff then 0000", mem_log.size());
      end
      fetch(14'h3FFF, w);
      vectors++;
      if (w != 1) begin miscompares++; $display("FAIL wrap_hit_3fff: %0d cycles, required 1", w); end
      fetch(14'h0000, w);
      vectors++;
      if (w != 1) begin miscompares++; $display("FAIL wrap_hit_0000: %0d cycles, required 1", w); end
      idle(1);
   endtask

   task automatic test_async_reset();
      int w;
      int budget;
      lat = 2;
      fetch(14'h200, w);
      mem_log.delete();
      bus.cpu_req = 1'b0;
      budget = 0;
      while (mem_log.size() < 4 && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      vectors += 2;
      if (mem_log.size() < 4) begin miscompares++; $display("FAIL areset_fill: %0d requests, required 4", mem_log.size()); end
      if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL areset_setup: mem_req=%b, required 1", bus.mem_req); end
      #2 rst = 1'b1;
      #1;
      vectors += 4;
      if (bus.mem_req !== 1'b0)    begin miscompares++; $display("FAIL areset_mem_req: %b, required 0", bus.mem_req); end
      if (bus.mem_addr !== '0)     begin miscompares++; $display("FAIL areset_mem_addr: %h, required 0", bus.mem_addr); end
      if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL areset_rdata: %h, required 0", bus.cpu_rdata); end
      if (bus.cpu_valid !== 1'b0 || bus.cpu_wait !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_ctrl: valid=%b wait=%b, required 0 / 0", bus.cpu_valid, bus.cpu_wait);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_log.delete();
      fetch(14'h010, w);
      vectors += 2;
      if (w != 4) begin miscompares++; $display("FAIL post_reset_latency: %0d cycles, required 4", w); end
      if (mem_log.size() < 1 || mem_log[0] !== 14'h010) begin
         miscompares++;
         $display("FAIL post_reset_req: %0d requests logged, required first 010", mem_log.size());
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_fill_stream();
      test_redirect_discard();
      test_redirect_inflight();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule

// File: doc/im_prefetch.md
# im_prefetch

Instruction prefetch queue between the CPU fetch port (IM_CS / IM_A / IM_DO) and a variable-latency instruction memory. It fetches consecutive instruction words ahead of the CPU into a small in-order queue. It answers sequential fetches in one cycle, exactly like a synchronous SRAM. On any non-sequential fetch (branch or jump redirect) it flushes and refetches, reporting the wait to the controller.

## Interface
- DEPTH, 4, number of queue entries (power of two, ≥2)
- AW, 14, word-address width (matches IM_A)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  fetch request (driven from IM_CS)
- cpu_addr  in  AW  word address of the request (driven from IM_A)
- cpu_rdata  out  32  instruction word; holds its value between deliveries
- cpu_valid  out  1  cpu_rdata is the word requested in the previous cycle
- cpu_wait  out  1  a miss is pending; controller must stall the PC
- mem_req  out  1  memory read request
- mem_addr  out  AW  memory word address; stable while mem_req=1
- mem_rvalid  in  1  response for the single outstanding request
- mem_rdata  in  32  response data, valid with mem_rvalid

## Operation
- Queue entries hold {addr, data} for consecutive addresses, oldest at the head.
- pf_addr is the next address to request. It equals head.addr+count when no flush is outstanding, and wraps modulo 2^AW (0x3FFF+1 = 0x0000).
- **Memory side:** at most one outstanding request (inflight).
  - Issue mem_req with mem_addr=pf_addr when inflight=0, count<DEPTH, and no response is arriving in that cycle.
  - mem_req stays high and mem_addr stays unchanged until mem_rvalid; mem_req drops in the cycle after mem_rvalid.
- **Response handling:** on mem_rvalid, inflight clears and one of three cases applies:
  - discard=1: drop the data and clear discard.
  - pending=1 and response address == pend_addr: deliver to the CPU, do not push, set pf_addr=pend_addr+1, clear pending.
  - Otherwise: push {pf_addr, mem_rdata}, then increment pf_addr.
- **Hit:** cpu_req=1 and count>0 and head.addr==cpu_addr.
  - Pop the head, register its data into cpu_rdata, and pulse cpu_valid for the next cycle.
- **Miss** (cpu_req=1, not a hit, and pending=0 or cpu_addr≠pend_addr):
  - Flush the queue (count=0), set pending=1, pend_addr=cpu_addr, pf_addr=cpu_addr.
  - If inflight=1 and its address ≠ cpu_addr, or the queue was non-empty, set discard=1 for the in-flight response.
  - If inflight=1, the queue was empty, and the in-flight address == cpu_addr, keep that request (no discard).
  - An outstanding request is never cancelled; mem_req/mem_addr stay held until its response.
- **While pending:**
  - The CPU holds cpu_req and cpu_addr; repeats of the same address have no effect.
  - A different address is a new miss and re-redirects.
- cpu_req=0: no pop, cpu_valid=0 next cycle, prefetch continues.
- Simultaneous push and pop in one cycle: count unchanged, order preserved. A push at count==DEPTH cannot occur, because no request is issued when the queue is full.
- A miss in the same cycle as a response: the response is handled under the pre-miss state (pushed entries are flushed). Only a response equal to the new cpu_addr with an empty queue is delivered.

## Timing
- Reset values: cpu_rdata=0, cpu_valid=0, cpu_wait=0, mem_req=0, mem_addr=0. Internally count=0, inflight=0, pending=0, discard=0, pf_addr=0.
- Reset mid-transaction drops all state immediately.
  - A memory response arriving after reset release is ignored, since inflight=0.
  - The memory model must not return responses for requests issued before reset.
- Hit latency: cpu_req at cycle N → cpu_valid=1 at N+1, matching SRAM timing.
- Miss latency, memory idle: cpu_req at N → mem_req at N+1 → cpu_valid at R+1, where R is the mem_rvalid cycle.
- cpu_wait is registered: high from N+1 through the cycle of mem_rvalid for pend_addr, low in the cycle where cpu_valid=1.
- Back-to-back sequential hits sustain one word per cycle while the queue is non-empty.

## Test plan
- **Cold start:** reset, then cpu_req addr 0x000, memory latency 2.
  - mem_req/mem_addr=0x000 at cycle 1, cpu_wait=1.
  - rvalid at cycle 3 with 0x00000013 → cpu_valid=1, cpu_rdata=0x00000013 at cycle 4, cpu_wait=0.
- **Fill and stream:** CPU idles after the first word.
  - Queue fills 0x001–0x004, mem_req stays low at count=4.
  - Then cpu_req 0x001..0x004 on consecutive cycles → four consecutive cpu_valid pulses with the matching data. Prefetch resumes after the first pop.
- **Redirect with a request in flight** to 0x005, latency 5: cpu_req 0x100.
  - mem_addr holds 0x005 until rvalid and that data is dropped.
  - The next mem_addr is 0x100; cpu_valid rises only for the 0x100 data.
- **Redirect to the in-flight address:** queue empty, request for 0x020 in flight, cpu_req 0x020.
  - No discard; data delivered one cycle after rvalid; no second request to 0x020.
- **Wrap-around:** cpu_req 0x3FFE → prefetch requests 0x3FFF then 0x0000. cpu_req 0x3FFF then 0x0000 both hit.
- **Async reset while mem_req=1 and count=3:** all outputs go to 0 without a clock edge. After release, cpu_req 0x010 produces a clean miss sequence.
